// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
//   Shared definitions for the MEM/WB commit stage (writeback_ctrl).
//   - wb_state_t : commit FSM states
//   - REG_ADDR_W : register-file address width
//   - TMR_W      : width of the load-wait counter (covers LOAD_TIMEOUT up to 255)
//   - data_w(n)  : datum width for n 8-bit residue domains
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int TMR_W      = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    COMMIT_LD = 2'd2
  } wb_state_t;

  function automatic int data_w(input int n);
    return n * 8;
  endfunction

endpackage

// File: rtl/wb_load_timer.sv
// -----------------------------------------------------------------------------
// wb_load_timer
//   Clear/enable up-counter that measures how long a load has been waiting.
//   tc (terminal count) is asserted combinationally in the enabled cycle whose
//   increment brings the count to LOAD_TIMEOUT, so the owner can act on it in
//   the same cycle (i.e. after exactly LOAD_TIMEOUT enabled cycles).
//
//   Ports:
//     clk  in   system clock, rising edge
//     rst  in   asynchronous, active-high reset (count -> 0)
//     clr  in   synchronous clear (takes priority over en)
//     en   in   count enable
//     tc   out  terminal count reached this cycle
// -----------------------------------------------------------------------------
module wb_load_timer
  import wb_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TMR_W-1:0] TC_VAL = TMR_W'(LOAD_TIMEOUT - 1);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = en && (count_q == TC_VAL);

endmodule

// File: rtl/writeback_ctrl.sv
// -----------------------------------------------------------------------------
// writeback_ctrl
//   MEM/WB commit stage. Registers EX (ALU) results and data-memory load
//   returns and drives the register-file write port, which the forwarding
//   unit snoops. One load may be outstanding; while it waits, ID is stalled.
//   A load that does not return within LOAD_TIMEOUT cycles is abandoned and
//   flagged on the sticky load_timeout_err.
//
//   Parameters:
//     NUM_DOMAINS   number of 8-bit residue domains per datum
//     LOAD_TIMEOUT  LOAD_WAIT cycles before a load is abandoned (1..255)
//
//   Build option:
//     WB_LOAD_EARLY_RELEASE_EN  when defined, stall_ID drops already in the
//                               LOAD_WAIT cycle that sees mem_rd_valid.
//                               Commit timing is unaffected.
//
//   Ports:
//     clk, rst              clock / async active-high reset
//     ex_valid, ex_wr_en,   EX instruction valid, writes a reg, is a load
//     ex_load
//     ex_dest_addr          EX destination register
//     ex_result             EX ALU result
//     mem_rd_valid          load data valid (1-cycle pulse)
//     mem_rd_data           load data
//     wr_data               register-file write data
//     destination_reg_addr  register-file write address
//     reg_wr_en             register-file write enable (1 cycle per commit)
//     load_true_wb          current commit carries load data
//     stall_ID              hold IF/ID (combinational from state)
//     load_timeout_err      sticky: a load was abandoned
// -----------------------------------------------------------------------------
module writeback_ctrl
  import wb_pkg::*;
#(
  parameter int NUM_DOMAINS  = 1,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ex_valid,
  input  logic                                ex_wr_en,
  input  logic                                ex_load,
  input  logic [REG_ADDR_W-1:0]               ex_dest_addr,
  input  logic [data_w(NUM_DOMAINS)-1:0]      ex_result,
  input  logic                                mem_rd_valid,
  input  logic [data_w(NUM_DOMAINS)-1:0]      mem_rd_data,
  output logic [data_w(NUM_DOMAINS)-1:0]      wr_data,
  output logic [REG_ADDR_W-1:0]               destination_reg_addr,
  output logic                                reg_wr_en,
  output logic                                load_true_wb,
  output logic                                stall_ID,
  output logic                                load_timeout_err
);

  localparam int DW = data_w(NUM_DOMAINS);

  wb_state_t             state_q,   state_d;
  logic [DW-1:0]         wr_data_q, wr_data_d;
  logic [REG_ADDR_W-1:0] addr_q,    addr_d;
  logic [REG_ADDR_W-1:0] ld_dest_q, ld_dest_d;
  logic                  wr_en_q,   wr_en_d;
  logic                  ld_wb_q,   ld_wb_d;
  logic                  err_q,     err_d;

  logic tmr_clr;
  logic tmr_en;
  logic tmr_tc;

  wb_load_timer #(
    .LOAD_TIMEOUT (LOAD_TIMEOUT)
  ) u_load_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tmr_tc)
  );

  // Next-state and commit-register logic.
  // NOTE: every signal written here is given a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    wr_data_d = wr_data_q;
    addr_d    = addr_q;
    ld_dest_d = ld_dest_q;
    wr_en_d   = 1'b0;
    ld_wb_d   = 1'b0;
    err_d     = err_q;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;

    unique case (state_q)
      // COMMIT_LD has stall_ID low, so an instruction that ID released may
      // already be in EX; it is accepted exactly as in IDLE.
      IDLE, COMMIT_LD: begin
        state_d = IDLE;
        if (ex_valid && ex_load) begin
          // Loads always write a register; ex_wr_en is irrelevant here.
          ld_dest_d = ex_dest_addr;
          tmr_clr   = 1'b1;
          state_d   = LOAD_WAIT;
        end else if (ex_valid && ex_wr_en) begin
          wr_en_d   = 1'b1;
          wr_data_d = ex_result;
          addr_d    = ex_dest_addr;
        end
      end

      LOAD_WAIT: begin
        tmr_en = 1'b1;
        // Returning data takes priority over a timeout in the same cycle.
        if (mem_rd_valid) begin
          wr_en_d   = 1'b1;
          ld_wb_d   = 1'b1;
          wr_data_d = mem_rd_data;
          addr_d    = ld_dest_q;
          state_d   = COMMIT_LD;
        end else if (tmr_tc) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_data_q <= '0;
      addr_q    <= '0;
      ld_dest_q <= '0;
      wr_en_q   <= 1'b0;
      ld_wb_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_data_q <= wr_data_d;
      addr_q    <= addr_d;
      ld_dest_q <= ld_dest_d;
      wr_en_q   <= wr_en_d;
      ld_wb_q   <= ld_wb_d;
      err_q     <= err_d;
    end
  end

`ifdef WB_LOAD_EARLY_RELEASE_EN
  assign stall_ID = (state_q == LOAD_WAIT) && !mem_rd_valid;
`else
  assign stall_ID = (state_q == LOAD_WAIT);
`endif

  assign wr_data              = wr_data_q;
  assign destination_reg_addr = addr_q;
  assign reg_wr_en            = wr_en_q;
  assign load_true_wb         = ld_wb_q;
  assign load_timeout_err     = err_q;

endmodule
